alu16_arbiter: RTL
==================

# alu16_arbiter

Two-requester round-robin arbiter and response buffer wrapped around one shared `alu16` instance. Each requester presents an op/A/B triple on a valid/ready channel. The arbiter grants at most one request per cycle to the ALU and registers the result and zero flag into that requester's private response buffer. The buffer is drained on a valid/ready response channel. This lets two independent sequencers share one 16-bit ALU without duplicating the datapath.

## Interface
Parameters:
- `RR_INIT`, default 0: requester that holds priority after reset (0 or 1).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0 operation accepted this cycle.
- `req0_op`  in  3  ALU opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV B, 6/7 zero.
- `req0_a`, `req0_b`  in  16  operands.
- `rsp0_valid`  out  1  response buffer 0 holds a result.
- `rsp0_ready`  in  1  requester 0 consumes its result.
- `rsp0_y`  out  16  result.
- `rsp0_zf`  out  1  result == 0.
- `req1_*`, `rsp1_*`  same as channel 0, for requester 1.
- `last_grant`  out  1  index of the most recently granted requester.

## Operation
- Eligibility: `elig_i = reqi_valid && (!rspi_valid || rspi_ready)`. A requester is eligible only if its buffer is empty or is being drained this cycle.
- Grant selection:
  - Both eligible: grant goes to the requester `prio` points at.
  - One eligible: that requester is granted.
  - None eligible: no grant.
- `reqi_ready = grant_i`, combinational. It depends on `reqi_valid` and `rspi_ready`, never on the other requester's ready.
- Datapath: a mux steers the granted requester's op/a/b into the single `alu16`. The ALU output `y`/`zf` is captured into the granted buffer at the clock edge.
- Priority: after any grant, `prio` becomes the other requester. With no grant, `prio` is held.
- Response buffer i, per edge:
  - Load on grant_i: `rspi_valid` goes to 1 and y/zf are replaced. A load overrides a same-cycle drain.
  - Otherwise a drain (`rspi_valid && rspi_ready`) clears `rspi_valid`.
  - Otherwise all fields hold.
- `rspi_y`/`rspi_zf` stay stable while `rspi_valid=1` and not drained.
- Opcodes 6 and 7 produce y=0, zf=1. They are accepted like any other op, not rejected.
- All arithmetic is modulo 2^16. No carry or overflow is exported.

## Timing
- Reset (async assert, sampled deassert):
  - `rsp0_valid`, `rsp1_valid` = 0.
  - `rsp*_y` = 0x0000, `rsp*_zf` = 0.
  - `prio` = RR_INIT, `last_grant` = RR_INIT.
  - `req*_ready` is low while `rst` = 1.
- Latency: a request accepted at edge N has its result visible in `rspi_*` immediately after edge N (one cycle).
- Throughput:
  - One accepted operation per cycle in aggregate.
  - One requester alone sustains 1/cycle if `rspi_ready` is held at 1.
  - Both contending at full rate get alternate cycles.
- Backpressure: while `rspi_valid=1` and `rspi_ready=0`, requester i is not granted. The other requester may take every cycle.
- Reset during an outstanding response discards it. No partial state survives.

## Test plan
- Single ADD: RR_INIT=0, req0 op=0, a=0x0003, b=0x0004. Expect `req0_ready`=1 in the same cycle, then next cycle `rsp0_valid`=1, y=0x0007, zf=0, `last_grant`=0.
- Round-robin: both valid continuously, both rsp_ready=1, RR_INIT=0. Expect grant sequence 0,1,0,1,… with no idle cycles, and each rsp_valid pulsing every other cycle.
- Backpressure:
  - `rsp0_ready`=0 after the first req0 result. Expect `req0_ready`=0 indefinitely, `rsp0_y` stable, and req1 granted every cycle.
  - Raising `rsp0_ready` restores alternation.
- ALU corner ops:
  - SUB 0x0000−0x0001 → y=0xFFFF, zf=0.
  - XOR 0xA5A5^0xA5A5 → y=0, zf=1.
  - MOV b=0x1234 → y=0x1234.
  - op=7 → y=0, zf=1.
- Drain-and-reload: req0 valid every cycle with `rsp0_ready`=1. Expect `rsp0_valid` to stay 1 across consecutive cycles with a new y each cycle, and no dropped or duplicated results.
- Mid-stream reset: assert `rst` asynchronously while `rsp1_valid`=1. Expect `rsp1_valid`=0 and y=0 before the next edge, and after release the first contended grant goes to RR_INIT.

Source files
------------

// File: rtl/alu16_arbiter.sv
// -----------------------------------------------------------------------------
// alu16_arbiter
//   Two-requester round-robin front end sharing a single 16-bit ALU. Each
//   requester issues op/A/B on a valid/ready request channel. The result and
//   zero flag are captured into that requester's private one-entry response
//   buffer, which is drained through a valid/ready response channel.
//
//   Ports
//     clk, rst                     clock, asynchronous active-high reset
//     reqN_valid / reqN_ready      request handshake (reqN_ready = grant N)
//     reqN_op, reqN_a, reqN_b      opcode (0 ADD,1 SUB,2 AND,3 OR,4 XOR,
//                                  5 MOV B,6/7 zero) and 16-bit operands
//     rspN_valid / rspN_ready      response handshake
//     rspN_y, rspN_zf              buffered result and zero flag
//     last_grant                   index of the most recently granted requester
//
//   alu16 (also in this file)
//     i_op, i_a, i_b -> o_y, o_zf  purely combinational 16-bit ALU
// -----------------------------------------------------------------------------

module alu16 (
   input  logic [2:0]  i_op,
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   output logic [15:0] o_y,
   output logic        o_zf
);
   logic [15:0] w_y;

   // Add/sub wrap modulo 2^16; carry and overflow are deliberately dropped.
   always_comb begin
      w_y = 16'h0000;
      case (i_op)
         3'd0:    w_y = i_a + i_b;
         3'd1:    w_y = i_a - i_b;
         3'd2:    w_y = i_a & i_b;
         3'd3:    w_y = i_a | i_b;
         3'd4:    w_y = i_a ^ i_b;
         3'd5:    w_y = i_b;
         default: w_y = 16'h0000;
      endcase
   end

   assign o_y  = w_y;
   assign o_zf = (w_y == 16'h0000);
endmodule

module alu16_arbiter #(
   parameter int RR_INIT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [2:0]  req0_op,
   input  logic [15:0] req0_a,
   input  logic [15:0] req0_b,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [15:0] rsp0_y,
   output logic        rsp0_zf,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [2:0]  req1_op,
   input  logic [15:0] req1_a,
   input  logic [15:0] req1_b,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [15:0] rsp1_y,
   output logic        rsp1_zf,
   output logic        last_grant
);
   localparam int   DATA_W     = 16;
   localparam logic LP_RR_INIT = (RR_INIT != 0);

   logic              r_prio;
   logic              r_last_grant;
   logic              r_rsp0_vld_p1;
   logic [DATA_W-1:0] r_rsp0_y_p1;
   logic              r_rsp0_zf_p1;
   logic              r_rsp1_vld_p1;
   logic [DATA_W-1:0] r_rsp1_y_p1;
   logic              r_rsp1_zf_p1;

   logic              w_elig0;
   logic              w_elig1;
   logic              w_gnt0;
   logic              w_gnt1;
   logic [2:0]        w_alu_op;
   logic [DATA_W-1:0] w_alu_a;
   logic [DATA_W-1:0] w_alu_b;
   logic [DATA_W-1:0] w_alu_y;
   logic              w_alu_zf;

   // A requester may issue only if its buffer is free or being emptied now.
   // Gating with rst keeps both ready outputs low throughout reset.
   assign w_elig0 = req0_valid & (~r_rsp0_vld_p1 | rsp0_ready) & ~rst;
   assign w_elig1 = req1_valid & (~r_rsp1_vld_p1 | rsp1_ready) & ~rst;

   // r_prio names the requester that wins when both are eligible.
   assign w_gnt0 = w_elig0 & (~w_elig1 | ~r_prio);
   assign w_gnt1 = w_elig1 & (~w_elig0 |  r_prio);

   assign req0_ready = w_gnt0;
   assign req1_ready = w_gnt1;

   // Stage p0: steer the granted request into the shared ALU.
   assign w_alu_op = w_gnt1 ? req1_op : req0_op;
   assign w_alu_a  = w_gnt1 ? req1_a  : req0_a;
   assign w_alu_b  = w_gnt1 ? req1_b  : req0_b;

   alu16 u_alu (
      .i_op (w_alu_op),
      .i_a  (w_alu_a),
      .i_b  (w_alu_b),
      .o_y  (w_alu_y),
      .o_zf (w_alu_zf)
   );

   // Stage p1: response buffers and round-robin state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prio        <= LP_RR_INIT;
         r_last_grant  <= LP_RR_INIT;
         r_rsp0_vld_p1 <= 1'b0;
         r_rsp0_y_p1   <= '0;
         r_rsp0_zf_p1  <= 1'b0;
         r_rsp1_vld_p1 <= 1'b0;
         r_rsp1_y_p1   <= '0;
         r_rsp1_zf_p1  <= 1'b0;
      end else begin
         // Priority passes to the requester that was not just served.
         if (w_gnt0 | w_gnt1) begin
            r_prio       <= w_gnt0;
            r_last_grant <= w_gnt1;
         end

         // A load wins over a same-cycle drain, so back-to-back results
         // keep the buffer valid without a bubble.
         if (w_gnt0) begin
            r_rsp0_vld_p1 <= 1'b1;
            r_rsp0_y_p1   <= w_alu_y;
            r_rsp0_zf_p1  <= w_alu_zf;
         end else if (r_rsp0_vld_p1 && rsp0_ready) begin
            r_rsp0_vld_p1 <= 1'b0;
         end

         if (w_gnt1) begin
            r_rsp1_vld_p1 <= 1'b1;
            r_rsp1_y_p1   <= w_alu_y;
            r_rsp1_zf_p1  <= w_alu_zf;
         end else if (r_rsp1_vld_p1 && rsp1_ready) begin
            r_rsp1_vld_p1 <= 1'b0;
         end
      end
   end

   assign rsp0_valid = r_rsp0_vld_p1;
   assign rsp0_y     = r_rsp0_y_p1;
   assign rsp0_zf    = r_rsp0_zf_p1;
   assign rsp1_valid = r_rsp1_vld_p1;
   assign rsp1_y     = r_rsp1_y_p1;
   assign rsp1_zf    = r_rsp1_zf_p1;
   assign last_grant = r_last_grant;
endmodule
